// File: rtl/pipeline_3.sv
// EX/MEM pipeline register.
// Carries the EX-stage control bits, ALU result, store data, destination index
// and next-PC into the MEM stage. A memory stall (BUSY_WAIT) freezes the whole
// register at once, so no field can update on its own. RESET clears every field
// asynchronously, and it also wins over a stall.
module pipeline_3 (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        BUSY_WAIT,
   input  logic        REG_DEST,
   input  logic        REG_WRITE,
   input  logic [2:0]  MEM_READ,
   input  logic [1:0]  MEM_TO_REG,
   input  logic [2:0]  MEM_WRITE,
   input  logic        BRANCH_RES,
   input  logic [31:0] ALU_RESULT,
   input  logic [31:0] OUT2,
   input  logic [4:0]  IN_ADDRESS,
   input  logic [31:0] PC_NEXT,
   output logic        BRANCH_RES_OUT,
   output logic        REG_DEST_OUT,
   output logic        REG_WRITE_OUT,
   output logic [2:0]  MEM_READ_OUT,
   output logic [2:0]  MEM_WRITE_OUT,
   output logic [1:0]  MEM_TO_REG_OUT,
   output logic [4:0]  IN_ADDRESS_OUT,
   output logic [31:0] ALU_RESULT_OUT,
   output logic [31:0] OUT2_OUT,
   output logic [31:0] PC_NEXT_OUT
);

   // Shared load enable. Every field uses it, so a stall freezes all of them together.
   logic load_en;

   // The register loads only on a clock edge where memory is not stalling.
   assign load_en = ~BUSY_WAIT;

   // Pipeline register: asynchronous clear, otherwise load when load_en is set.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         BRANCH_RES_OUT <= 1'b0;
         REG_DEST_OUT   <= 1'b0;
         REG_WRITE_OUT  <= 1'b0;
         MEM_READ_OUT   <= 3'd0;
         MEM_WRITE_OUT  <= 3'd0;
         MEM_TO_REG_OUT <= 2'd0;
         IN_ADDRESS_OUT <= 5'd0;
         ALU_RESULT_OUT <= 32'd0;
         OUT2_OUT       <= 32'd0;
         PC_NEXT_OUT    <= 32'd0;
      end else if (load_en) begin
         BRANCH_RES_OUT <= BRANCH_RES;
         REG_DEST_OUT   <= REG_DEST;
         REG_WRITE_OUT  <= REG_WRITE;
         MEM_READ_OUT   <= MEM_READ;
         MEM_WRITE_OUT  <= MEM_WRITE;
         MEM_TO_REG_OUT <= MEM_TO_REG;
         IN_ADDRESS_OUT <= IN_ADDRESS;
         ALU_RESULT_OUT <= ALU_RESULT;
         OUT2_OUT       <= OUT2;
         PC_NEXT_OUT    <= PC_NEXT;
      end
   end

endmodule

// File: tb/tb_pipeline_3.sv
// Self-checking bench for the EX/MEM pipeline register pipeline_3.
// All input fields and all output fields are packed into 112-bit vectors that
// use the same field order: {br, rd, rw, mr[3], mw[3], mtr[2], ia[5], alu[32], out2[32], pc[32]}.
module tb_pipeline_3;

   logic        CLK;
   logic        RESET;
   logic        BUSY_WAIT;
   logic [111:0] in_vec;
   logic [111:0] out_vec;
   logic [111:0] model;
   logic [111:0] exp_q[$];
   int          n_checks;
   int          n_fail;

   logic        REG_DEST, REG_WRITE, BRANCH_RES;
   logic [2:0]  MEM_READ, MEM_WRITE;
   logic [1:0]  MEM_TO_REG;
   logic [4:0]  IN_ADDRESS;
   logic [31:0] ALU_RESULT, OUT2, PC_NEXT;
   logic        BRANCH_RES_OUT, REG_DEST_OUT, REG_WRITE_OUT;
   logic [2:0]  MEM_READ_OUT, MEM_WRITE_OUT;
   logic [1:0]  MEM_TO_REG_OUT;
   logic [4:0]  IN_ADDRESS_OUT;
   logic [31:0] ALU_RESULT_OUT, OUT2_OUT, PC_NEXT_OUT;

   assign {BRANCH_RES, REG_DEST, REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG,
           IN_ADDRESS, ALU_RESULT, OUT2, PC_NEXT} = in_vec;
   assign out_vec = {BRANCH_RES_OUT, REG_DEST_OUT, REG_WRITE_OUT, MEM_READ_OUT,
                     MEM_WRITE_OUT, MEM_TO_REG_OUT, IN_ADDRESS_OUT,
                     ALU_RESULT_OUT, OUT2_OUT, PC_NEXT_OUT};

   pipeline_3 dut (
      .CLK(CLK), .RESET(RESET), .BUSY_WAIT(BUSY_WAIT),
      .REG_DEST(REG_DEST), .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ),
      .MEM_TO_REG(MEM_TO_REG), .MEM_WRITE(MEM_WRITE), .BRANCH_RES(BRANCH_RES),
      .ALU_RESULT(ALU_RESULT), .OUT2(OUT2), .IN_ADDRESS(IN_ADDRESS),
      .PC_NEXT(PC_NEXT),
      .BRANCH_RES_OUT(BRANCH_RES_OUT), .REG_DEST_OUT(REG_DEST_OUT),
      .REG_WRITE_OUT(REG_WRITE_OUT), .MEM_READ_OUT(MEM_READ_OUT),
      .MEM_WRITE_OUT(MEM_WRITE_OUT), .MEM_TO_REG_OUT(MEM_TO_REG_OUT),
      .IN_ADDRESS_OUT(IN_ADDRESS_OUT), .ALU_RESULT_OUT(ALU_RESULT_OUT),
      .OUT2_OUT(OUT2_OUT), .PC_NEXT_OUT(PC_NEXT_OUT)
   );

   // 10 ns system clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: sim time %0t exceeded limit", $time);
      $fatal(1, "timeout");
   end

   function automatic logic [111:0] pack(
      input logic br, input logic rd, input logic rw,
      input logic [2:0] mr, input logic [2:0] mw, input logic [1:0] mtr,
      input logic [4:0] ia, input logic [31:0] alu, input logic [31:0] o2,
      input logic [31:0] pc);
      return {br, rd, rw, mr, mw, mtr, ia, alu, o2, pc};
   endfunction

   task automatic check_val(input string tag, input logic [111:0] obs,
                            input logic [111:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Push the current model value as the expected result, then pop the oldest
   // entry and compare it with the DUT outputs.
   task automatic sb_check(input string tag);
      logic [111:0] e;
      exp_q.push_back(model);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h expected entry", tag, out_vec);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, out_vec, e);
      end
   endtask

   // Wait for the next rising edge, update the model from what the bench
   // drove at that edge, then check 2 ns after the edge.
   task automatic edge_check(input string tag);
      @(posedge CLK);
      if (RESET && !BUSY_WAIT) model = in_vec;
      else if (!RESET) model = '0;
      #2;
      sb_check(tag);
   endtask

   // Drive inputs on the falling edge, then check after the next rising edge.
   task automatic apply(input logic [111:0] v, input logic busy, input string tag);
      @(negedge CLK);
      in_vec    = v;
      BUSY_WAIT = busy;
      edge_check(tag);
   endtask

   logic [111:0] v_a, v_b, v_c, v_ones, v_tmp;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      model     = '0;
      RESET     = 1'b0;
      BUSY_WAIT = 1'b0;
      v_a    = pack(1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 2'd1, 5'd4, 32'd10, 32'd12, 32'd10);
      v_b    = pack(1'b1, 1'b1, 1'b1, 3'd3, 3'd4, 2'd1, 5'd4, 32'd56, 32'd42, 32'd10);
      v_c    = pack(1'b1, 1'b1, 1'b1, 3'd2, 3'd4, 2'd1, 5'd4, 32'd6,  32'd42, 32'd8);
      v_ones = {112{1'b1}};
      in_vec = v_a;

      // Reset asserted from time 0: outputs are zero before any edge and
      // stay zero across edges.
      #1;
      sb_check("reset_initial");
      edge_check("reset_held_edge");

      // Load nonzero values, then pulse RESET between edges and check that
      // the outputs clear without a clock.
      @(negedge CLK);
      RESET = 1'b1;
      apply(v_a, 1'b0, "load_a");
      #1 RESET = 1'b0;
      model = '0;
      #1 sb_check("async_reset_pulse");
      RESET = 1'b1;

      // Normal load, then a stall that holds the previous values.
      apply(v_b, 1'b0, "load_b");
      apply(v_c, 1'b1, "stall_hold");
      apply(v_c, 1'b1, "stall_hold2");

      // Inputs change between edges while not stalled: outputs stay put.
      apply(v_a, 1'b0, "load_a2");
      #1 in_vec = v_b;
      #1 sb_check("midcycle_no_prop");
      edge_check("load_after_mid");

      // BUSY_WAIT glitches between edges do not matter; only its value at the edge does.
      @(negedge CLK);
      in_vec = v_c;
      BUSY_WAIT = 1'b1;
      #2 BUSY_WAIT = 1'b0;
      edge_check("busy_glitch_load");
      @(negedge CLK);
      in_vec = v_a;
      BUSY_WAIT = 1'b0;
      #2 BUSY_WAIT = 1'b1;
      edge_check("busy_glitch_hold");

      // Reset during a stall clears the register. It stays clear across an
      // edge and then loads once reset is released.
      apply(v_b, 1'b1, "stall_before_reset");
      #1 RESET = 1'b0;
      model = '0;
      #1 sb_check("reset_mid_stall");
      edge_check("reset_low_edge");
      @(negedge CLK);
      RESET = 1'b1;
      BUSY_WAIT = 1'b0;
      in_vec = v_b;
      edge_check("load_after_reset");

      // All ones: confirms every bit of every field is carried.
      apply(v_ones, 1'b0, "all_ones");
      apply('0, 1'b0, "all_zero_bubble");

      // Random traffic with random stalls.
      for (int i = 0; i < 24; i++) begin
         v_tmp = {$urandom, $urandom, $urandom, $urandom};
         apply(v_tmp, ($urandom_range(0, 2) == 0), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_3.md
PIPELINE_3 -- requirements
Module: pipeline_3

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset (RESET=0 clears all state).
REQ-004 BUSY_WAIT  input  1  stall request from memory; 1 freezes the register.
REQ-005 REG_DEST  input  1  EX-stage register-destination control bit.
REQ-006 REG_WRITE  input  1  EX-stage register-file write enable.
REQ-007 MEM_READ  input  3  EX-stage memory read type code.
REQ-008 MEM_TO_REG  input  2  EX-stage write-back source select.
REQ-009 MEM_WRITE  input  3  EX-stage memory write type code.
REQ-010 BRANCH_RES  input  1  EX-stage branch resolution result.
REQ-011 ALU_RESULT  input  32  ALU output / memory address.
REQ-012 OUT2  input  32  second register-file operand (store data).
REQ-013 IN_ADDRESS  input  5  destination register index.
REQ-014 PC_NEXT  input  32  next-PC value carried forward.
REQ-015 BRANCH_RES_OUT, REG_DEST_OUT, REG_WRITE_OUT  output  1 each  registered copies.
REQ-016 MEM_READ_OUT, MEM_WRITE_OUT  output  3 each  registered copies.
REQ-017 MEM_TO_REG_OUT  output  2  registered copy.
REQ-018 IN_ADDRESS_OUT  output  5  registered copy.
REQ-019 ALU_RESULT_OUT, OUT2_OUT, PC_NEXT_OUT  output  32 each  registered copies.
REQ-020 Port order SHALL be: CLK, RESET, BUSY_WAIT, REG_DEST, REG_WRITE, MEM_READ, MEM_TO_REG, MEM_WRITE, BRANCH_RES, ALU_RESULT, OUT2, IN_ADDRESS, PC_NEXT, BRANCH_RES_OUT, REG_DEST_OUT, REG_WRITE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, MEM_TO_REG_OUT, IN_ADDRESS_OUT, ALU_RESULT_OUT, OUT2_OUT, PC_NEXT_OUT.

Function
REQ-021 The block SHALL be the EX/MEM pipeline register: each *_OUT is a register holding its same-named input, bit-exact, no transformation or width change.
REQ-022 On a CLK rising edge with RESET=1 and BUSY_WAIT=0, every register SHALL capture its input; latency one clock.
REQ-023 On a CLK rising edge with RESET=1 and BUSY_WAIT=1, every register SHALL hold its current value (all fields stall together; no partial update).
REQ-024 BUSY_WAIT SHALL be sampled only at the rising edge; toggling between edges SHALL have no effect.
REQ-025 Outputs SHALL change only at a rising edge or on reset assertion, and SHALL be settled no later than 1 ns after the edge.
REQ-026 Input changes between edges SHALL NOT propagate to outputs (no combinational path input->output).
REQ-027 There is no flush input; a bubble is inserted upstream by driving control inputs to 0.

Reset
REQ-028 RESET=0 SHALL immediately, without waiting for CLK, force every output to 0 (all control bits, codes, IN_ADDRESS_OUT, ALU_RESULT_OUT, OUT2_OUT, PC_NEXT_OUT).
REQ-029 While RESET=0, outputs SHALL stay 0 regardless of CLK, BUSY_WAIT or inputs.
REQ-030 Reset SHALL override BUSY_WAIT; reset asserted mid-stall clears the register.
REQ-031 After RESET returns to 1, the first rising edge with BUSY_WAIT=0 SHALL load inputs normally.

Verification
REQ-032 Inputs nonzero (ALU_RESULT=10, OUT2=12, PC_NEXT=10, IN_ADDRESS=4, controls 1/1/1, MEM_READ=3, MEM_WRITE=4, MEM_TO_REG=1), pulse RESET=0 between edges -> all outputs 0 before any clock edge.
REQ-033 RESET=1, BUSY_WAIT=0, ALU_RESULT=56, OUT2=42, PC_NEXT=10, IN_ADDRESS=4, MEM_READ=3, MEM_WRITE=4, MEM_TO_REG=1, 1-bit controls=1 -> 2 ns after next rising edge outputs equal those values.
REQ-034 Then BUSY_WAIT=1, ALU_RESULT=6, MEM_READ=2, PC_NEXT=8 -> after next edge outputs still ALU_RESULT_OUT=56, MEM_READ_OUT=3, PC_NEXT_OUT=10, others unchanged.
REQ-035 Change inputs mid-cycle with BUSY_WAIT=0 -> outputs unchanged until next rising edge.
REQ-036 BUSY_WAIT=1 held, assert RESET=0 -> outputs clear to 0 asynchronously; release RESET, BUSY_WAIT=0 -> next edge loads inputs.
REQ-037 Drive all-ones inputs (0xFFFFFFFF, 5'h1F, 3'h7, 2'h3) -> outputs all-ones after one edge, confirming full width with no truncation.
